// File: rtl/aes_key_expander_if.sv
// Key-expander port bundle: key hand-off from the front-end plus the
// round-key SRAM write port and schedule status.
interface aes_key_expander_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              key_valid;
    logic [127:0]      key_in;
    logic              busy;
    logic              rk_wr_en;
    logic [ADDR_W-1:0] rk_addr;
    logic [127:0]      rk_data;
    logic              key_done;
    logic              key_loaded;

    // Front-end / SRAM side
    modport master (
        output key_valid, key_in,
        input  busy, rk_wr_en, rk_addr, rk_data, key_done, key_loaded
    );

    // Key expander side
    modport slave (
        input  key_valid, key_in,
        output busy, rk_wr_en, rk_addr, rk_data, key_done, key_loaded
    );
endinterface

// File: rtl/aes_key_expander.sv
// AES-128 key schedule: expands one cipher key into 11 round keys, one per
// cycle, written straight into the round-key SRAM.
module aes_key_expander #(
    parameter int unsigned NROUNDS = 10,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    aes_key_expander_if.slave bus
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_EXPAND = 1'b1;

    // Forward S-box, byte 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_ROM = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte b lives at bit offset 8*(255-b), and 255-b is simply ~b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_ROM[{~b, 3'b000} +: 8];
    endfunction

    // Round constant for rounds 1..10.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    logic [0:0]        state;
    logic [0:0]        state_next;
    logic [127:0]      w;
    logic [127:0]      w_next;
    logic [127:0]      w_round;
    logic [ADDR_W-1:0] rnd;
    logic [ADDR_W-1:0] rnd_next;
    logic [ADDR_W-1:0] rnd_inc;
    logic              done_q;
    logic              done_next;
    logic              loaded_q;
    logic              loaded_next;
    logic [31:0]       t;
    logic [31:0]       w0n;
    logic [31:0]       w1n;
    logic [31:0]       w2n;
    logic [31:0]       w3n;

    assign rnd_inc = rnd + ADDR_W'(1);

    // One key-schedule round: derive the next round key from the current one.
    always_comb begin
        t = {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])}
            ^ {rcon(rnd_inc[3:0]), 24'h000000};
        w0n     = w[127:96] ^ t;
        w1n     = w[95:64]  ^ w0n;
        w2n     = w[63:32]  ^ w1n;
        w3n     = w[31:0]   ^ w2n;
        w_round = {w0n, w1n, w2n, w3n};
    end

    // Next-state and datapath update; w/rnd hold in IDLE so the SRAM port keeps its last value.
    always_comb begin
        state_next  = state;
        w_next      = w;
        rnd_next    = rnd;
        done_next   = 1'b0;
        loaded_next = loaded_q;
        case (state)
            S_IDLE: begin
                if (bus.key_valid) begin
                    state_next  = S_EXPAND;
                    w_next      = bus.key_in;
                    rnd_next    = '0;
                    loaded_next = 1'b0;
                end
            end
            S_EXPAND: begin
                if (rnd == ADDR_W'(NROUNDS)) begin
                    state_next  = S_IDLE;
                    done_next   = 1'b1;
                    loaded_next = 1'b1;
                end else begin
                    w_next   = w_round;
                    rnd_next = rnd_inc;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and working registers; reset wipes the schedule status.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= S_IDLE;
            w        <= '0;
            rnd      <= '0;
            done_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            state    <= state_next;
            w        <= w_next;
            rnd      <= rnd_next;
            done_q   <= done_next;
            loaded_q <= loaded_next;
        end
    end

    // SRAM port and status come straight from registers.
    assign bus.busy       = state[0];
    assign bus.rk_wr_en   = state[0];
    assign bus.rk_addr    = rnd;
    assign bus.rk_data    = w;
    assign bus.key_done   = done_q;
    assign bus.key_loaded = loaded_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander: stimulus queues expected SRAM
// writes, a negedge monitor pops and compares every write strobe.
module tb_aes_key_expander;

    typedef struct {
        logic [3:0]   addr;
        logic [127:0] data;
        bit           chk;
    } exp_t;

    logic clk;
    logic n_rst;
    int   errors;
    int   checks;
    int   wr_cnt;
    exp_t exp_q[$];

    logic [127:0] fips_rk [11];
    logic [127:0] zero_rk [11];
    bit           zero_chk [11];

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] OTHER_KEY = 128'h6c6f6c7a20676f6f64206b6579206869;

    aes_key_expander_if #(.ADDR_W(4)) bus ();

    aes_key_expander #(.NROUNDS(10), .ADDR_W(4)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_sched(input bit zero);
        exp_t e;
        for (int i = 0; i < 11; i++) begin
            e.addr = 4'(i);
            e.data = zero ? zero_rk[i] : fips_rk[i];
            e.chk  = zero ? zero_chk[i] : 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int start, output int cyc);
        cyc = -1;
        for (int i = start; i < start + 40; i++) begin
            @(negedge clk);
            if (bus.key_done) begin
                cyc = i;
                break;
            end
        end
    endtask

    // Checks at the completion cycle and the cycle after it.
    task automatic finish_checks(input string tag, input int cyc, input int base);
        check({tag, "_latency"}, 128'(cyc), 128'd12);
        check({tag, "_done_busy"}, 128'(bus.busy), 128'd0);
        check({tag, "_done_wr_en"}, 128'(bus.rk_wr_en), 128'd0);
        check({tag, "_loaded"}, 128'(bus.key_loaded), 128'd1);
        check({tag, "_write_count"}, 128'(wr_cnt - base), 128'd11);
        @(negedge clk);
        check({tag, "_done_pulse"}, 128'(bus.key_done), 128'd0);
        check({tag, "_loaded_hold"}, 128'(bus.key_loaded), 128'd1);
        check({tag, "_queue_drained"}, 128'(exp_q.size()), 128'd0);
    endtask

    task automatic run_single(input string tag, input logic [127:0] k, input bit zero);
        int cyc;
        int base;
        base = wr_cnt;
        bus.key_in    = k;
        bus.key_valid = 1'b1;
        push_sched(zero);
        @(negedge clk);
        bus.key_valid = 1'b0;
        check({tag, "_busy_c1"}, 128'(bus.busy), 128'd1);
        check({tag, "_loaded_cleared"}, 128'(bus.key_loaded), 128'd0);
        wait_done(2, cyc);
        finish_checks(tag, cyc, base);
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        exp_t e;
        if (bus.rk_wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 128'(bus.rk_addr), 128'hf);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 128'(bus.rk_addr), 128'(e.addr));
                if (e.chk) check("write_data", bus.rk_data, e.data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        int  base;
        bit  found;

        fips_rk[0]  = FIPS_KEY;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i < 11; i++) begin
            zero_rk[i]  = '0;
            zero_chk[i] = 1'b0;
        end
        zero_rk[1]   = 128'h62636363626363636263636362636363;
        zero_rk[10]  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        zero_chk[0]  = 1'b1;
        zero_chk[1]  = 1'b1;
        zero_chk[10] = 1'b1;

        errors        = 0;
        checks        = 0;
        wr_cnt        = 0;
        n_rst         = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_in    = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_wr_en", 128'(bus.rk_wr_en), 128'd0);
        check("rst_addr", 128'(bus.rk_addr), 128'd0);
        check("rst_data", bus.rk_data, 128'd0);
        check("rst_done", 128'(bus.key_done), 128'd0);
        check("rst_loaded", 128'(bus.key_loaded), 128'd0);
        n_rst = 1'b1;

        // Idle hold
        repeat (100) begin
            @(negedge clk);
            check("idle_flags", 128'({bus.busy, bus.rk_wr_en, bus.key_done, bus.key_loaded}), 128'd0);
        end

        // FIPS-197 key and all-zero key
        run_single("fips", FIPS_KEY, 1'b0);
        check("idle_hold_addr", 128'(bus.rk_addr), 128'd10);
        check("idle_hold_data", bus.rk_data, fips_rk[10]);
        run_single("zero", '0, 1'b1);

        // key_valid during EXPAND is ignored
        base = wr_cnt;
        bus.key_in    = FIPS_KEY;
        bus.key_valid = 1'b1;
        push_sched(1'b0);
        @(negedge clk);
        bus.key_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rk_wr_en && bus.rk_addr == 4'd5) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("ign_reach_r5", 128'(found), 128'd1);
        bus.key_in    = OTHER_KEY;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_in    = '0;
        check("ign_addr_r6", 128'(bus.rk_addr), 128'd6);
        wait_done(8, cyc);
        finish_checks("ign", cyc, base);

        // Reset mid-EXPAND
        bus.key_in    = FIPS_KEY;
        bus.key_valid = 1'b1;
        push_sched(1'b0);
        @(negedge clk);
        bus.key_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.rk_wr_en && bus.rk_addr == 4'd4) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("mid_reach_r4", 128'(found), 128'd1);
        #1 n_rst = 1'b0;
        #1;
        check("mid_rst_busy", 128'(bus.busy), 128'd0);
        check("mid_rst_wr_en", 128'(bus.rk_wr_en), 128'd0);
        check("mid_rst_addr", 128'(bus.rk_addr), 128'd0);
        check("mid_rst_data", bus.rk_data, 128'd0);
        check("mid_rst_done", 128'(bus.key_done), 128'd0);
        check("mid_rst_loaded", 128'(bus.key_loaded), 128'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", 128'(bus.busy), 128'd0);
        check("post_rst_loaded", 128'(bus.key_loaded), 128'd0);
        run_single("post_rst", FIPS_KEY, 1'b0);

        // Back-to-back keys with key_valid held high
        base = wr_cnt;
        bus.key_in    = FIPS_KEY;
        bus.key_valid = 1'b1;
        push_sched(1'b0);
        @(negedge clk);
        bus.key_in = '0;
        push_sched(1'b1);
        wait_done(2, cyc);
        check("b2b_latency1", 128'(cyc), 128'd12);
        check("b2b_loaded1", 128'(bus.key_loaded), 128'd1);
        check("b2b_idle_busy", 128'(bus.busy), 128'd0);
        @(negedge clk);
        bus.key_valid = 1'b0;
        check("b2b_accept_busy", 128'(bus.busy), 128'd1);
        check("b2b_accept_addr", 128'(bus.rk_addr), 128'd0);
        check("b2b_loaded_one_cycle", 128'(bus.key_loaded), 128'd0);
        check("b2b_done_low", 128'(bus.key_done), 128'd0);
        wait_done(2, cyc);
        check("b2b_latency2", 128'(cyc), 128'd12);
        check("b2b_loaded2", 128'(bus.key_loaded), 128'd1);
        check("b2b_write_count", 128'(wr_cnt - base), 128'd22);
        check("b2b_queue_drained", 128'(exp_q.size()), 128'd0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
